// File: rtl/usbf_wb_pkg.sv
// Shared definitions for the USB function Wishbone register slave:
// FSM encoding, register-bank geometry and address-decode boundaries.
package usbf_wb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } wb_state_e;

  localparam int REG_NUM = 8;
  localparam logic [2:0] STATUS_IDX = 3'd7;

  // Register index lives in adr[4:2]; any set bit at or above MAP_LSB is unmapped.
  localparam int IDX_LSB = 2;
  localparam int IDX_W   = 3;
  localparam int MAP_LSB = 5;

endpackage

// File: rtl/usbf_wb_slave.sv
// Wishbone slave with seven read/write config registers, one read-only status
// word, programmable wait states and error termination for unmapped addresses.
module usbf_wb_slave
  import usbf_wb_pkg::*;
#(
  parameter int dwidth   = 32,
  parameter int awidth   = 18,
  parameter int WAIT_CYC = 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [awidth-1:0]     adr_i,
  input  logic [dwidth-1:0]     dat_i,
  output logic [dwidth-1:0]     dat_o,
  input  logic                  cyc_i,
  input  logic                  stb_i,
  input  logic                  we_i,
  output logic                  ack_o,
  output logic                  err_o,
  input  logic [dwidth-1:0]     status_i,
  output logic [7*dwidth-1:0]   cfg_o,
  output logic [6:0]            wr_pulse_o
);

  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYC);

  wb_state_e         state;
  logic [3:0]        cnt;
  logic [awidth-1:0] adr_q;
  logic [dwidth-1:0] dat_q;
  logic              we_q;

  logic              req;
  logic              enter_resp;
  logic [awidth-1:0] eff_adr;
  logic [dwidth-1:0] eff_dat;
  logic              eff_we;
  logic [IDX_W-1:0]  eff_idx;
  logic              eff_map;

  assign req = cyc_i & stb_i;

  // With zero wait states the response is decided on the sampling edge itself,
  // so the live bus is used; otherwise the values latched in IDLE are used.
  always_comb begin
    eff_adr    = adr_q;
    eff_dat    = dat_q;
    eff_we     = we_q;
    enter_resp = 1'b0;
    if (state == IDLE) begin
      eff_adr    = adr_i;
      eff_dat    = dat_i;
      eff_we     = we_i;
      enter_resp = req && (WAIT_CYC == 0);
    end else if (state == WAIT) begin
      enter_resp = req && (cnt == 4'd1);
    end
    eff_idx = eff_adr[IDX_LSB +: IDX_W];
    eff_map = (eff_adr[awidth-1:MAP_LSB] == '0);
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state      <= IDLE;
      cnt        <= '0;
      adr_q      <= '0;
      dat_q      <= '0;
      we_q       <= 1'b0;
      ack_o      <= 1'b0;
      err_o      <= 1'b0;
      dat_o      <= '0;
      wr_pulse_o <= '0;
      cfg_o      <= '0;
    end else begin
      ack_o      <= 1'b0;
      err_o      <= 1'b0;
      dat_o      <= '0;
      wr_pulse_o <= '0;

      case (state)
        IDLE: begin
          if (req) begin
            cnt   <= WAIT_INIT;
            adr_q <= adr_i;
            dat_q <= dat_i;
            we_q  <= we_i;
            state <= (WAIT_CYC == 0) ? RESP : WAIT;
          end
        end
        WAIT: begin
          if (!req) begin
            state <= IDLE;
            cnt   <= '0;
          end else if (cnt == 4'd1) begin
            state <= RESP;
            cnt   <= '0;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase

      // Termination, register write and read data all land on the edge into RESP.
      if (enter_resp) begin
        if (!eff_map) begin
          err_o <= 1'b1;
        end else begin
          ack_o <= 1'b1;
          if (eff_we) begin
            if (eff_idx != STATUS_IDX) begin
              cfg_o[eff_idx*dwidth +: dwidth] <= eff_dat;
              wr_pulse_o[eff_idx]             <= 1'b1;
            end
          end else if (eff_idx == STATUS_IDX) begin
            dat_o <= status_i;
          end else begin
            dat_o <= cfg_o[eff_idx*dwidth +: dwidth];
          end
        end
      end
    end
  end

endmodule

// File: doc/usbf_wb_slave.md
USBF_WB_SLAVE -- requirements
Module: usbf_wb_slave

Interface
REQ-001 The block SHALL have parameter dwidth, default 32, meaning data bus width.
REQ-002 The block SHALL have parameter awidth, default 18, meaning byte address width.
REQ-003 The block SHALL have parameter WAIT_CYC, default 1, range 0..15, meaning inserted wait states before the response.
REQ-004 The block SHALL have port clk_i  input  1  the single clock, all logic rising-edge.
REQ-005 The block SHALL have port rst_i  input  1  reset, asynchronous, active-low.
REQ-006 The block SHALL have port adr_i  input  awidth  byte address from the initiator.
REQ-007 The block SHALL have port dat_i  input  dwidth  write data.
REQ-008 The block SHALL have port dat_o  output  dwidth  read data.
REQ-009 The block SHALL have ports cyc_i, stb_i, we_i  input  1 each  cycle, strobe and write-enable.
REQ-010 The block SHALL have port ack_o  output  1  normal termination.
REQ-011 The block SHALL have port err_o  output  1  error termination.
REQ-012 The block SHALL have port status_i  input  dwidth  read-only status word.
REQ-013 The block SHALL have port cfg_o  output  7*dwidth  registers 0..6, register k at bits [k*dwidth +: dwidth].
REQ-014 The block SHALL have port wr_pulse_o  output  7  one-cycle pulse per register written.

Function
REQ-015 Register index SHALL be adr_i[4:2]; the address SHALL be mapped only when adr_i[awidth-1:5]==0, and adr_i[1:0] SHALL be ignored.
REQ-016 The FSM SHALL have states IDLE, WAIT and RESP, and SHALL reset to IDLE.
REQ-017 In IDLE, sampling cyc_i&stb_i high SHALL load the wait counter with WAIT_CYC, latch adr_i/dat_i/we_i, and enter WAIT (or RESP when WAIT_CYC==0).
REQ-018 WAIT SHALL decrement the counter each cycle and enter RESP when it reaches 1.
REQ-019 Latency SHALL be exactly WAIT_CYC+1 cycles from the sampling edge to ack_o/err_o high.
REQ-020 ack_o or err_o SHALL be high for exactly one cycle (RESP), never both, and the FSM SHALL then return to IDLE.
REQ-021 After RESP, the next request SHALL be accepted no earlier than the following IDLE cycle, giving a minimum 1-cycle gap.
REQ-022 If cyc_i or stb_i drops during WAIT, the FSM SHALL abort to IDLE with no termination, no write and no pulse.
REQ-023 On a mapped write to index 0..6, the register SHALL update on the edge entering RESP, and the matching wr_pulse_o bit SHALL be high during RESP.
REQ-024 A write to index 7 SHALL be acknowledged and ignored.
REQ-025 On a mapped read, dat_o SHALL equal the register (index 7: status_i sampled on the edge entering RESP) during RESP, and SHALL be 0 otherwise.
REQ-026 An unmapped access SHALL assert err_o instead of ack_o with the same timing, with no write, no pulse, and dat_o=0.
REQ-027 Inputs sampled in IDLE SHALL be held; changes to adr_i/dat_i/we_i during WAIT SHALL have no effect.

Reset
REQ-028 Asserting rst_i low SHALL force, immediately: state IDLE, counter 0, ack_o=0, err_o=0, dat_o=0, wr_pulse_o=0, all cfg_o registers 0.
REQ-029 A transaction in flight at reset SHALL be discarded without termination, and operation SHALL resume in IDLE on the first edge after release.

Structure
REQ-030 State encoding, REG_NUM=8, STATUS_IDX=7 and the mapped-address check width SHALL reside in shared package usbf_wb_pkg.
REQ-031 The block SHALL be a single module with no sub-module; the register bank is inline.

Verification
REQ-032 Write: WAIT_CYC=1, write 0xDEADBEEF to adr 0x08 -> ack_o high on 2nd edge after sampling, wr_pulse_o=7'b0000100, cfg_o[95:64]=0xDEADBEEF.
REQ-033 Read: read adr 0x08 after REQ-032 -> dat_o=0xDEADBEEF only in the ack cycle; read adr 0x1C with status_i=0x00001234 -> 0x00001234.
REQ-034 Error: write to adr 0x20 -> err_o one cycle, ack_o=0, cfg_o unchanged, wr_pulse_o=0.
REQ-035 Abort: WAIT_CYC=3, stb_i dropped after 1 cycle -> no ack_o/err_o, register unchanged.
REQ-036 Reset: rst_i low during WAIT -> all outputs 0 asynchronously; after release, a read of adr 0x00 returns 0.
REQ-037 Back-to-back: WAIT_CYC=0, stb_i held high across two writes -> acks on cycles 1 and 3, both registers written.
